// File: rtl/hwag_angle_gen.sv
//==============================================================================
// Module      : hwag_angle_gen
// Description : Crank angle generator. Interpolates 64 angle steps per tooth
//               from the last tooth period, with a 192-step span on the gap tooth.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module hwag_angle_gen #(
    parameter int PCNT_WIDTH = 24,
    parameter int TCNT_WIDTH = 6,
    parameter int TCNT_TOP   = 57
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sync,
    input  logic                  tooth_stb,
    input  logic [TCNT_WIDTH-1:0] tooth_idx,
    input  logic [PCNT_WIDTH-1:0] period,
    output logic [11:0]           acnt,
    output logic                  acnt_tick,
    output logic                  acnt_valid,
    output logic                  jump,
    output logic                  err
);

    localparam int                    c_spw       = PCNT_WIDTH - 6;
    localparam logic [TCNT_WIDTH-1:0] c_tcnt_top  = TCNT_WIDTH'(TCNT_TOP);
    localparam logic [7:0]            c_lim_norm  = 8'd63;
    localparam logic [7:0]            c_lim_gap   = 8'd191;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state, w_state_nx;
    logic [11:0]      r_acnt, w_acnt_nx;
    logic             r_tick, w_tick_nx;
    logic             r_valid, w_valid_nx;
    logic             r_jump, w_jump_nx;
    logic             r_err, w_err_nx;
    logic [c_spw-1:0] r_timer, w_timer_nx;
    logic [c_spw-1:0] r_step_per, w_step_per_nx;
    logic [7:0]       r_sub, w_sub_nx;
    logic [7:0]       r_limit, w_limit_nx;

    logic [c_spw-1:0] w_per_div;
    logic [7:0]       w_sub_inc;
    logic             w_idx_bad;
    logic             w_unused_period_lsbs;

    // The low six period bits are below one step's resolution.
    assign w_unused_period_lsbs = ^period[5:0];
    assign w_per_div            = period[PCNT_WIDTH-1:6];
    assign w_sub_inc            = r_sub + 8'd1;
    assign w_idx_bad            = (tooth_idx > c_tcnt_top);

    always_comb begin
        w_state_nx    = r_state;
        w_acnt_nx     = r_acnt;
        w_tick_nx     = 1'b0;
        w_valid_nx    = r_valid;
        w_jump_nx     = 1'b0;
        w_err_nx      = 1'b0;
        w_timer_nx    = r_timer;
        w_step_per_nx = r_step_per;
        w_sub_nx      = r_sub;
        w_limit_nx    = r_limit;

        if (!sync) begin
            w_state_nx = S_IDLE;
            w_acnt_nx  = 12'd0;
            w_valid_nx = 1'b0;
            w_timer_nx = '0;
            w_sub_nx   = 8'd0;
        end else if (tooth_stb && w_idx_bad) begin
            w_err_nx   = 1'b1;
            w_state_nx = S_IDLE;
            w_acnt_nx  = 12'd0;
            w_valid_nx = 1'b0;
            w_timer_nx = '0;
            w_sub_nx   = 8'd0;
        end else if (tooth_stb) begin
            // A new tooth always resynchronises, even on a coincident step tick.
            w_state_nx    = S_RUN;
            w_acnt_nx     = 12'({tooth_idx, 6'b0});
            w_valid_nx    = 1'b1;
            w_timer_nx    = '0;
            w_sub_nx      = 8'd0;
            w_step_per_nx = (w_per_div == '0) ? c_spw'(1) : w_per_div;
            w_limit_nx    = (tooth_idx == c_tcnt_top) ? c_lim_gap : c_lim_norm;
            w_jump_nx     = (r_state == S_RUN) && (r_sub < r_limit);
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_timer == r_step_per - c_spw'(1)) begin
                        w_timer_nx = '0;
                        w_sub_nx   = w_sub_inc;
                        w_acnt_nx  = r_acnt + 12'd1;
                        w_tick_nx  = 1'b1;
                        if (w_sub_inc >= r_limit) begin
                            w_state_nx = S_HOLD;
                        end
                    end else begin
                        w_timer_nx = r_timer + c_spw'(1);
                    end
                end
                S_HOLD:  w_state_nx = S_HOLD;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_acnt     <= 12'd0;
            r_tick     <= 1'b0;
            r_valid    <= 1'b0;
            r_jump     <= 1'b0;
            r_err      <= 1'b0;
            r_timer    <= '0;
            r_step_per <= c_spw'(1);
            r_sub      <= 8'd0;
            r_limit    <= c_lim_norm;
        end else begin
            r_state    <= w_state_nx;
            r_acnt     <= w_acnt_nx;
            r_tick     <= w_tick_nx;
            r_valid    <= w_valid_nx;
            r_jump     <= w_jump_nx;
            r_err      <= w_err_nx;
            r_timer    <= w_timer_nx;
            r_step_per <= w_step_per_nx;
            r_sub      <= w_sub_nx;
            r_limit    <= w_limit_nx;
        end
    end

    assign acnt       = r_acnt;
    assign acnt_tick  = r_tick;
    assign acnt_valid = r_valid;
    assign jump       = r_jump;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_hwag_angle_gen.sv
//==============================================================================
// Module      : tb_hwag_angle_gen
// Description : Self-checking bench for hwag_angle_gen (vector table + scoreboard).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hwag_angle_gen;

    typedef struct packed {
        logic [11:0] acnt;
        logic        tick;
        logic        valid;
        logic        jump;
        logic        err;
    } exp_t;

    typedef struct {
        string       name;
        logic        r;
        logic        s;
        logic        stb;
        logic [5:0]  idx;
        logic [23:0] per;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sync = 1'b0;
    logic        tooth_stb = 1'b0;
    logic [5:0]  tooth_idx = 6'd0;
    logic [23:0] period = 24'd0;
    logic [11:0] acnt;
    logic        acnt_tick;
    logic        acnt_valid;
    logic        jump;
    logic        err;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t tbl[10];

    hwag_angle_gen #(
        .PCNT_WIDTH (24),
        .TCNT_WIDTH (6),
        .TCNT_TOP   (57)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sync       (sync),
        .tooth_stb  (tooth_stb),
        .tooth_idx  (tooth_idx),
        .period     (period),
        .acnt       (acnt),
        .acnt_tick  (acnt_tick),
        .acnt_valid (acnt_valid),
        .jump       (jump),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int a, input logic t, v, j, e);
        exp_t x;
        x.acnt  = 12'(a);
        x.tick  = t;
        x.valid = v;
        x.jump  = j;
        x.err   = e;
        return x;
    endfunction

    function automatic vec_t mv(input string n, input logic r, s, st, input int ix,
                                input int pr, input exp_t e);
        vec_t v;
        v.name = n; v.r = r; v.s = s; v.stb = st;
        v.idx = 6'(ix); v.per = 24'(pr); v.e = e;
        return v;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic check_pop(input string nm);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            if ({acnt, acnt_tick, acnt_valid, jump, err} !== e) begin
                bad++;
                $display("FAIL %s: got acnt=%0d tick=%b valid=%b jump=%b err=%b expected acnt=%0d tick=%b valid=%b jump=%b err=%b",
                         nm, acnt, acnt_tick, acnt_valid, jump, err,
                         e.acnt, e.tick, e.valid, e.jump, e.err);
            end
        end
    endtask

    task automatic apply(input string nm, input logic r, s, st, input int ix,
                         input int pr, input exp_t e);
        sb.push_back(e);
        @(negedge clk);
        rst = r; sync = s; tooth_stb = st; tooth_idx = 6'(ix); period = 24'(pr);
        @(posedge clk);
        #1;
        check_pop(nm);
    endtask

    // Free-running model: ticks every 'per' cycles after the strobe until 'lim' steps.
    task automatic run_steps(input string nm, input int n, input int per,
                             input int base, input int lim);
        int   errs = 0;
        int   first = -1;
        int   sub = 0;
        exp_t e, got;
        for (int c = 1; c <= n; c++) begin
            e = mk(base + sub, 1'b0, 1'b1, 1'b0, 1'b0);
            if ((sub < lim) && (c % per == 0)) begin
                sub++;
                e = mk(base + sub, 1'b1, 1'b1, 1'b0, 1'b0);
            end
            sb.push_back(e);
            @(negedge clk);
            rst = 1'b1; sync = 1'b1; tooth_stb = 1'b0;
            @(posedge clk);
            #1;
            got = {acnt, acnt_tick, acnt_valid, jump, err};
            e = sb.pop_front();
            if (got !== e) begin
                errs++;
                if (first < 0) first = c;
            end
        end
        cmp({nm, " bad cycles"}, errs, 0);
        if (errs != 0) cmp({nm, " first bad cycle"}, first, 0);
        cmp({nm, " final acnt"}, int'(acnt), base + sub);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = mv("idle_no_sync",   1, 0, 0,  0,    0, mk(0,    0, 0, 0, 0));
        tbl[1] = mv("stb_no_sync",    1, 0, 1,  5, 6400, mk(0,    0, 0, 0, 0));
        tbl[2] = mv("err_from_idle",  1, 1, 1, 60, 6400, mk(0,    0, 0, 0, 1));
        tbl[3] = mv("err_one_cycle",  1, 1, 0,  0,    0, mk(0,    0, 0, 0, 0));
        tbl[4] = mv("sync_idx5",      1, 1, 1,  5, 6400, mk(320,  0, 1, 0, 0));
        tbl[5] = mv("jump_idx10",     1, 1, 1, 10, 6400, mk(640,  0, 1, 1, 0));
        tbl[6] = mv("sync_over_stb",  1, 0, 1,  7, 6400, mk(0,    0, 0, 0, 0));
        tbl[7] = mv("gap_idx57",      1, 1, 1, 57, 6400, mk(3648, 0, 1, 0, 0));
        tbl[8] = mv("err_from_run",   1, 1, 1, 61, 6400, mk(0,    0, 0, 0, 1));
        tbl[9] = mv("idx0_per0",      1, 1, 1,  0,    0, mk(0,    0, 1, 0, 0));

        apply("reset_0", 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0));
        apply("reset_1", 0, 1, 1, 5, 6400, mk(0, 0, 0, 0, 0));

        for (int i = 0; i < 10; i++)
            apply(tbl[i].name, tbl[i].r, tbl[i].s, tbl[i].stb, tbl[i].idx, tbl[i].per, tbl[i].e);

        apply("to_idle", 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0));

        // Normal tooth: 63 steps every 100 cycles, then HOLD for 1000 cycles.
        apply("t5_start", 1, 1, 1, 5, 6400, mk(320, 0, 1, 0, 0));
        run_steps("t5_run", 7300, 100, 320, 63);

        // Gap tooth spans 191 steps to 3839, then wrap via idx 0.
        apply("t57_start", 1, 1, 1, 57, 6400, mk(3648, 0, 1, 0, 0));
        run_steps("t57_run", 19300, 100, 3648, 191);
        apply("t0_wrap", 1, 1, 1, 0, 6400, mk(0, 0, 1, 0, 0));

        // Early tooth: jump from 350 to 384.
        apply("t5_again", 1, 1, 1, 5, 6400, mk(320, 0, 1, 1, 0));
        run_steps("t5_partial", 3000, 100, 320, 63);
        apply("t6_jump", 1, 1, 1, 6, 6400, mk(384, 0, 1, 1, 0));
        run_steps("t6_partial", 99, 100, 384, 63);
        apply("t7_coincide", 1, 1, 1, 7, 6400, mk(448, 0, 1, 1, 0));

        // Short period: step_per clamps to 1.
        apply("t2_fast", 1, 1, 1, 2, 40, mk(128, 0, 1, 1, 0));
        run_steps("t2_run", 80, 1, 128, 63);

        // Sync drop mid-RUN.
        apply("t3_start", 1, 1, 1, 3, 6400, mk(192, 0, 1, 0, 0));
        run_steps("t3_run", 250, 100, 192, 63);
        apply("sync_drop", 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0));

        // Reset mid-RUN at acnt=1000, strobes during reset ignored.
        apply("t15_start", 1, 1, 1, 15, 640, mk(960, 0, 1, 0, 0));
        run_steps("t15_run", 400, 10, 960, 63);
        apply("rst_mid_run", 0, 1, 1, 20, 6400, mk(0, 0, 0, 0, 0));
        apply("rst_hold",    0, 1, 1, 21, 6400, mk(0, 0, 0, 0, 0));
        apply("rst_release", 1, 1, 0, 0, 0, mk(0, 0, 0, 0, 0));
        apply("post_rst_trail", 1, 1, 0, 0, 0, mk(0, 0, 0, 0, 0));
        apply("post_rst_t1", 1, 1, 1, 1, 6400, mk(64, 0, 1, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hwag_angle_gen.md
HWAG_ANGLE_GEN -- requirements
Module: hwag_angle_gen

Interface
REQ-001 The block SHALL have one parameter: PCNT_WIDTH, default 24, width of the tooth-period input.
REQ-002 The block SHALL have one parameter: TCNT_WIDTH, default 6, width of the tooth-index input.
REQ-003 The block SHALL have one parameter: TCNT_TOP, default 57, index of the gap tooth, which spans the last normal tooth plus 2 missing teeth.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port sync, input, 1 bit: the upstream synchronisation state ("hwag started").
REQ-007 The block SHALL have port tooth_stb, input, 1 bit: one-cycle strobe marking the start of a new tooth.
REQ-008 The block SHALL have port tooth_idx, input, TCNT_WIDTH bits: index of the tooth now starting; valid only with tooth_stb.
REQ-009 The block SHALL have port period, input, PCNT_WIDTH bits: last normal tooth period in clk cycles; valid only with tooth_stb.
REQ-010 The block SHALL have port acnt, output, 12 bits: angle count, 64 steps per tooth, 3840 steps per revolution.
REQ-011 The block SHALL have port acnt_tick, output, 1 bit: one-cycle pulse on each angle-step increment.
REQ-012 The block SHALL have port acnt_valid, output, 1 bit: acnt is synchronised.
REQ-013 The block SHALL have port jump, output, 1 bit: one-cycle pulse when a tooth starts before its 64 (or 192) steps are complete.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse when tooth_stb arrives with tooth_idx > TCNT_TOP.

Function
REQ-015 The block SHALL use a 3-state FSM: IDLE (unsynchronised), RUN (stepping), HOLD (step budget exhausted, waiting for the next tooth).
REQ-016 On tooth_stb with sync=1 and tooth_idx <= TCNT_TOP, in any state, the block SHALL, on the next cycle: set acnt = tooth_idx*64, clear the sub-step counter and the step timer, latch step_per, latch limit, set acnt_valid=1, and enter RUN.
REQ-017 The block SHALL compute the latched step_per as period[PCNT_WIDTH-1:6] (period/64, truncated).
REQ-018 If period/64 is 0, the block SHALL use step_per = 1 instead.
REQ-019 The block SHALL set the latched limit to 191 when tooth_idx == TCNT_TOP, and to 63 otherwise.
REQ-020 In RUN, the step timer SHALL increment every cycle.
REQ-021 In RUN, when the timer equals step_per-1, the block SHALL clear the timer, increment the sub-step counter and acnt by 1, and pulse acnt_tick on that same cycle's registered output.
REQ-022 In RUN, when the sub-step counter reaches limit, the block SHALL enter HOLD.
REQ-023 In HOLD, acnt SHALL freeze, acnt_tick SHALL stay 0, and acnt_valid SHALL stay 1.
REQ-024 The maximum acnt SHALL be 57*64+191 = 3839, and acnt SHALL never wrap to 0 except via a tooth_stb with tooth_idx=0.
REQ-025 If a valid tooth_stb arrives in RUN with sub-step < limit, the block SHALL pulse jump for one cycle.
REQ-026 If a valid tooth_stb coincides with a step tick, tooth_stb SHALL win: no acnt_tick, and acnt takes the tooth_idx*64 value.
REQ-027 If tooth_stb arrives with tooth_idx > TCNT_TOP, the block SHALL pulse err, ignore the strobe, and go to IDLE.
REQ-028 When sync=0 in any cycle, the block SHALL go to IDLE on the next cycle with acnt=0 and acnt_valid=0; sync=0 overrides a simultaneous tooth_stb.
REQ-029 In IDLE, tooth_stb with sync=0 SHALL be ignored.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 With rst=0 at a clock edge, the block SHALL enter IDLE with acnt=0, acnt_tick=0, acnt_valid=0, jump=0, err=0, timer=0, sub-step=0, step_per=1, limit=63.
REQ-032 Reset mid-RUN SHALL abort stepping with no trailing tick, and SHALL take priority over tooth_stb and sync.

Verification
REQ-033 The bench SHALL cover: sync=1, tooth_stb with idx=5, period=6400 -> acnt=320 next cycle, tick every 100 cycles, acnt=383 after 6300 cycles, HOLD, no further ticks for 1000 cycles.
REQ-034 The bench SHALL cover: tooth_stb with idx=57, period=6400 -> acnt 3648..3839 in 191 ticks; then tooth_stb with idx=0 -> acnt=0, no jump.
REQ-035 The bench SHALL cover: tooth_stb with idx=5, period=6400, then tooth_stb with idx=6 after 3000 cycles -> acnt 350 -> 384, jump pulse for one cycle.
REQ-036 The bench SHALL cover: period=40 -> step_per=1, acnt_tick every cycle for 63 cycles, then HOLD.
REQ-037 The bench SHALL cover: tooth_stb with idx=60 -> err pulse, IDLE, acnt_valid=0; and sync dropped mid-RUN -> acnt=0, acnt_valid=0 next cycle.
REQ-038 The bench SHALL cover: rst=0 asserted during RUN at acnt=1000 -> all outputs at reset values next cycle; tooth_stb during rst=0 ignored.
